gc_linebuffer_banked: RTL and testbench

//  Rotating multi-bank scanline buffer between the BG/sprite renderers and video scanout.

---
 rtl/gc_linebuffer_banked.sv | 172 +++++++++++++++++
 tb/tb_gc_linebuffer_banked.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gc_linebuffer_banked.sv
// Rotating multi-bank scanline buffer with clear-on-read scanout and an init clear sweep.
// Optional per-pixel priority compositing is enabled by defining GC_LINEBUFF_PRIO_EN.
module gc_linebuffer_banked #(
  parameter int BANK_W    = 2,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 8,
  parameter int PRIO_W    = 2,
  parameter int LINE_LEN  = 320,
  parameter int LAG       = 1,
  parameter int CLEAR_VAL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PRIO_W-1:0] wr_prio,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic [BANK_W-1:0] wr_bank,
  output logic [BANK_W-1:0] rd_bank,
  output logic              err_oob
);
  localparam int NBANK = 2 ** BANK_W;
  localparam int MEM_D = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   LEN_W       = (ADDR_W + 1)'(LINE_LEN);
  localparam logic [ADDR_W-1:0] LAST_PTR    = ADDR_W'(LINE_LEN - 1);
  localparam logic [DATA_W-1:0] CLR_D       = DATA_W'(CLEAR_VAL);
  localparam logic [BANK_W-1:0] RD_BANK_RST = BANK_W'(NBANK - LAG);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
  logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_oob_q, err_oob_d;

  logic              run_s, wr_in_s, rd_in_s, wr_land_s, clr_fire_s;
  logic [DATA_W-1:0] bank_rd_s [NBANK];

  assign run_s      = (state_q == ST_RUN);
  assign wr_in_s    = ({1'b0, wr_addr} < LEN_W);
  assign rd_in_s    = ({1'b0, rd_addr} < LEN_W);
  assign clr_fire_s = run_s & rd_en & rd_in_s;

`ifdef GC_LINEBUFF_PRIO_EN
  logic [PRIO_W-1:0] bank_prio_s [NBANK];
  // A cleared pixel holds prio 0, so the first write after a clear always lands.
  assign wr_land_s = run_s & wr_en & wr_in_s & (wr_prio >= bank_prio_s[wr_bank_q]);
`else
  logic unused_prio_s;
  assign unused_prio_s = ^wr_prio;
  assign wr_land_s     = run_s & wr_en & wr_in_s;
`endif

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [DATA_W-1:0] mem_q [MEM_D];
    logic              sel_wr_s, sel_rd_s;

    assign sel_wr_s = (wr_bank_q == BANK_W'(b));
    assign sel_rd_s = (rd_bank_q == BANK_W'(b));

    // Pixel storage: init sweep, render write, or scanout clear (never the same bank).
    always_ff @(posedge clk) begin
      if (!run_s) begin
        mem_q[clr_ptr_q] <= CLR_D;
      end else if (wr_land_s && sel_wr_s) begin
        mem_q[wr_addr] <= wr_data;
      end else if (clr_fire_s && sel_rd_s) begin
        mem_q[rd_addr] <= CLR_D;
      end
    end
    assign bank_rd_s[b] = mem_q[rd_addr];

`ifdef GC_LINEBUFF_PRIO_EN
    logic [PRIO_W-1:0] prio_q [MEM_D];

    // Priority storage follows the same write/clear schedule as the pixel data.
    always_ff @(posedge clk) begin
      if (!run_s) begin
        prio_q[clr_ptr_q] <= '0;
      end else if (wr_land_s && sel_wr_s) begin
        prio_q[wr_addr] <= wr_prio;
      end else if (clr_fire_s && sel_rd_s) begin
        prio_q[rd_addr] <= '0;
      end
    end
    assign bank_prio_s[b] = prio_q[wr_addr];
`endif
  end

  // Next-state: init sweep, read capture, OOB flag and bank rotation.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_oob_d  = err_oob_q;
    case (state_q)
      ST_INIT: begin
        if (clr_ptr_q == LAST_PTR) begin
          state_d   = ST_RUN;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (rd_en) begin
          rd_valid_d = 1'b1;
          rd_data_d  = rd_in_s ? bank_rd_s[rd_bank_q] : CLR_D;
        end else begin
          rd_valid_d = 1'b0;
        end
        if ((wr_en && !wr_in_s) || (rd_en && !rd_in_s)) begin
          err_oob_d = 1'b1;
        end else begin
          err_oob_d = err_oob_q;
        end
        // Accesses in this cycle already used the pre-rotation banks.
        if (line_start) begin
          wr_bank_d = wr_bank_q + BANK_W'(1);
          rd_bank_d = rd_bank_q + BANK_W'(1);
        end else begin
          wr_bank_d = wr_bank_q;
          rd_bank_d = rd_bank_q;
        end
      end
      default: begin
        state_d   = ST_INIT;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      clr_ptr_q  <= '0;
      wr_bank_q  <= '0;
      rd_bank_q  <= RD_BANK_RST;
      rd_data_q  <= CLR_D;
      rd_valid_q <= 1'b0;
      err_oob_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_oob_q  <= err_oob_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = ~run_s;
  assign wr_bank  = wr_bank_q;
  assign rd_bank  = rd_bank_q;
  assign err_oob  = err_oob_q;
endmodule

// File: tb/tb_gc_linebuffer_banked.sv
// Randomized + directed bench for gc_linebuffer_banked against a per-pixel array model.
module tb_gc_linebuffer_banked;
  localparam int LEN = 320;
  localparam int NB  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_start = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [8:0] wr_addr = 9'd0, rd_addr = 9'd0;
  logic [7:0] wr_data = 8'd0;
  logic [1:0] wr_prio = 2'd0;
  logic [7:0] rd_data;
  logic       rd_valid, busy, err_oob;
  logic [1:0] wr_bank, rd_bank;

  gc_linebuffer_banked dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_prio(wr_prio),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .wr_bank(wr_bank), .rd_bank(rd_bank), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_data [NB][512];
  int m_prio [NB][512];
  int m_wb, m_rb, m_init_left, m_rdata;
  bit m_err, m_valid;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wb = 0;
    m_rb = NB - 1;
    m_err = 1'b0;
    m_valid = 1'b0;
    m_rdata = 0;
    m_init_left = LEN;
    for (int b = 0; b < NB; b++)
      for (int x = 0; x < 512; x++) begin
        m_data[b][x] = 0;
        m_prio[b][x] = 0;
      end
  endtask

  // Reference model: one step per clock edge, from the pixel-level rules.
  always @(posedge clk) begin
    if (rst_n) begin
      if (m_init_left > 0) begin
        m_init_left--;
        m_valid = 1'b0;
      end else begin
        m_valid = rd_en;
        if (rd_en) begin
          if (int'(rd_addr) < LEN) begin
            m_rdata = m_data[m_rb][rd_addr];
            m_data[m_rb][rd_addr] = 0;
            m_prio[m_rb][rd_addr] = 0;
          end else begin
            m_rdata = 0;
            m_err = 1'b1;
          end
        end
        if (wr_en) begin
          if (int'(wr_addr) < LEN) begin
`ifdef GC_LINEBUFF_PRIO_EN
            if (int'(wr_prio) >= m_prio[m_wb][wr_addr]) begin
              m_data[m_wb][wr_addr] = int'(wr_data);
              m_prio[m_wb][wr_addr] = int'(wr_prio);
            end
`else
            m_data[m_wb][wr_addr] = int'(wr_data);
`endif
          end else begin
            m_err = 1'b1;
          end
        end
        if (line_start) begin
          m_wb = (m_wb + 1) % NB;
          m_rb = (m_rb + 1) % NB;
        end
      end
    end
  end

  // Compare process: every output against the model on the inactive edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_init_left != 0);
      chk("wr_bank", wr_bank, m_wb);
      chk("rd_bank", rd_bank, m_rb);
      chk("err_oob", err_oob, m_err);
      chk("rd_valid", rd_valid, m_valid);
      chk("rd_data", rd_data, m_rdata);
    end
  end

  task automatic cyc(input bit ls, input bit we, input int wa, input int wd, input int wp,
                     input bit re, input int ra);
    @(negedge clk);
    line_start = ls; wr_en = we; wr_addr = 9'(wa); wr_data = 8'(wd); wr_prio = 2'(wp);
    rd_en = re; rd_addr = 9'(ra);
    @(posedge clk);
    #1;
    line_start = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    line_start = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", busy, 1'b1);
    chk("rst_wr_bank", wr_bank, 2'd0);
    chk("rst_rd_bank", rd_bank, 2'd3);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_err_oob", err_oob, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic wait_init();
    int n = 0;
    while (busy && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("init_len", n, LEN);
  endtask

  task automatic rand_run(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      int wa, ra;
      wa = ($urandom_range(0, 24) == 0) ? 320 + $urandom_range(0, 100) : $urandom_range(0, 15);
      ra = ($urandom_range(0, 24) == 0) ? 319 + $urandom_range(0, 150) : $urandom_range(0, 15);
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, wa, $urandom_range(0, 255),
          $urandom_range(0, 3), $urandom_range(0, 1) == 1, ra);
    end
  endtask

  int exp_wb[6] = '{0, 1, 2, 3, 0, 1};
  int exp_rb[6] = '{3, 0, 1, 2, 3, 0};

  initial begin
    do_reset();
    wait_init();

    for (int k = 0; k < 6; k++) begin
      chk("rot_wr_bank", wr_bank, exp_wb[k]);
      chk("rot_rd_bank", rd_bank, exp_rb[k]);
      if (k < 5) cyc(1'b1, 1'b0, 0, 0, 0, 1'b0, 0);
    end

    for (int b = 0; b < NB; b++) begin
      for (int x = 0; x < LEN; x++) cyc(1'b0, 1'b0, 0, 0, 0, 1'b1, x);
      cyc(1'b1, 1'b0, 0, 0, 0, 1'b0, 0);
    end

    cyc(1'b0, 1'b1, 5, 8'h3A, 1, 1'b0, 0);
    cyc(1'b1, 1'b0, 0, 0, 0, 1'b0, 0);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1, 5);
    chk("t2_read", rd_data, 8'h3A);
    chk("t2_valid", rd_valid, 1'b1);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1, 5);
    chk("t2_reread", rd_data, 8'h00);

    cyc(1'b1, 1'b1, 7, 8'h11, 1, 1'b0, 0);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1, 7);
    chk("t4_old_bank", rd_data, 8'h11);

    chk("t5_err_before", err_oob, 1'b0);
    cyc(1'b0, 1'b1, 320, 8'h55, 3, 1'b0, 0);
    chk("t5_err_wr", err_oob, 1'b1);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1, 400);
    chk("t5_oob_data", rd_data, 8'h00);
    chk("t5_oob_valid", rd_valid, 1'b1);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, 0);
    chk("t5_valid_drop", rd_valid, 1'b0);
    chk("t5_err_sticky", err_oob, 1'b1);

    cyc(1'b0, 1'b1, 9, 8'h22, 2, 1'b0, 0);
    cyc(1'b0, 1'b1, 9, 8'h33, 1, 1'b0, 0);
    cyc(1'b0, 1'b1, 9, 8'h44, 2, 1'b0, 0);
    cyc(1'b1, 1'b0, 0, 0, 0, 1'b0, 0);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1, 9);
    chk("t6_prio_a", rd_data, 8'h44);
    cyc(1'b0, 1'b1, 9, 8'h22, 2, 1'b0, 0);
    cyc(1'b0, 1'b1, 9, 8'h44, 2, 1'b0, 0);
    cyc(1'b0, 1'b1, 9, 8'h33, 1, 1'b0, 0);
    cyc(1'b1, 1'b0, 0, 0, 0, 1'b0, 0);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1, 9);
`ifdef GC_LINEBUFF_PRIO_EN
    chk("t6_prio_b", rd_data, 8'h44);
`else
    chk("t6_prio_b", rd_data, 8'h33);
`endif

    rand_run(3000);
    do_reset();
    wait_init();
    rand_run(1500);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
